// File: rtl/key_pio_pkg.sv
// Shared constants and helpers for the key input PIO: register map and edge encodings.
package key_pio_pkg;

   // Word addresses of the Avalon-MM register map
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_DIR  = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Which debounced transition sets an edgecapture bit
   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

   // True when the old->new transition matches the selected edge type
   function automatic logic edge_hit(input int edge_type, input logic old_v, input logic new_v);
      logic hit;
      if (edge_type == int'(EDGE_RISE)) begin
         hit = ~old_v & new_v;
      end else if (edge_type == int'(EDGE_FALL)) begin
         hit = old_v & ~new_v;
      end else begin
         hit = old_v ^ new_v;
      end
      return hit;
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One input bit: synchroniser, tick-based stability counter, debounced level and edge pulse.
module key_debounce_bit
   import key_pio_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   DB_COUNT    = 4,
   parameter int   EDGE_TYPE   = 1,
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_tick,
   input  logic i_in,
   output logic o_level,
   output logic o_edge
);

   localparam int CW = $clog2(DB_COUNT + 1);
   // Value the counter holds on the tick that completes the stability window
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_level;
   logic                   r_level_d;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Shift the asynchronous input through the synchroniser chain
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      end
   end

   // Accept a new level only after it has differed for DB_COUNT consecutive ticks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_level <= RESET_LEVEL;
      end else if (i_tick) begin
         if (w_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Delayed copy of the level; reset to the same value so reset never looks like an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level_d <= RESET_LEVEL;
      end else begin
         r_level_d <= r_level;
      end
   end

   assign o_level = r_level;
   assign o_edge  = edge_hit(EDGE_TYPE, r_level_d, r_level);

endmodule

// File: rtl/key_pio_edge_irq.sv
// Avalon-MM input PIO: debounced key levels, edge capture with W1C, maskable registered IRQ.
module key_pio_edge_irq
   import key_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               SYNC_STAGES = 2,
   parameter int               TICK_DIV    = 50000,
   parameter int               DB_COUNT    = 4,
   parameter int               EDGE_TYPE   = 1,
   parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]    r_tick_cnt;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;
   logic             r_irq;
   logic             w_tick;
   logic             w_wr;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] w_edge;
   logic             w_unused_wdata;

   assign w_tick         = (r_tick_cnt == TICK_LAST);
   assign w_wr           = chipselect & ~write_n;
   assign w_clr          = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   // Upper write-data bits have no register behind them
   assign w_unused_wdata = &{1'b0, writedata};

   // Free-running debounce prescaler shared by all bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_bit
         key_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT),
            .EDGE_TYPE   (EDGE_TYPE),
            .RESET_LEVEL (RESET_LEVEL[g])
         ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .i_tick  (w_tick),
            .i_in    (in_port[g]),
            .o_level (w_level[g]),
            .o_edge  (w_edge[g])
         );
      end
   endgenerate

   // Interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqmask <= '0;
      end else if (w_wr && address == ADDR_MASK) begin
         r_irqmask <= writedata[WIDTH-1:0];
      end
   end

   // Edge capture: sticky set, write-1-to-clear, a new edge beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      end
   end

   // Registered level interrupt from any unmasked pending edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_edgecap & r_irqmask);
      end
   end

   assign irq = r_irq;

   // Zero-wait-state read mux, zero-extended to the bus width
   // NOTE: readdata gets a default before the case so no latch is inferred for unlisted paths.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata[WIDTH-1:0] = w_level;
         ADDR_DIR:  readdata = '0;
         ADDR_MASK: readdata[WIDTH-1:0] = r_irqmask;
         ADDR_EDGE: readdata[WIDTH-1:0] = r_edgecap;
         default:   readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_key_pio_edge_irq.sv
// Directed bench for key_pio_edge_irq with TICK_DIV=4, DB_COUNT=3, WIDTH=4, falling-edge capture.
module tb_key_pio_edge_irq;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0]      readdata;
   logic             irq;

   int n_assert = 0;
   int n_fail   = 0;

   key_pio_edge_irq #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .TICK_DIV    (4),
      .DB_COUNT    (3),
      .EDGE_TYPE   (1),
      .RESET_LEVEL (4'hF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Combinational read, sampled in the low phase of the clock
   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Single-cycle write strobe; returns at the following falling edge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Poll addr0 each cycle until it equals target; n = cycles waited, 0 on timeout
   task automatic wait_level(input logic [3:0] target, output int n);
      logic [31:0] d;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         rd(2'd0, d);
         if (d[3:0] == target) begin
            n = i;
            break;
         end
      end
   endtask

   // In-range latency check: 2 sync cycles, up to 3 cycles to the next tick, then 2 more ticks
   task automatic chk_latency(input string tag, input int n);
      n_assert++;
      assert (n >= 11 && n <= 14) else begin
         n_fail++;
         $error("FAIL %s: observed %0d cycles expected 11..14", tag, n);
      end
   endtask

   initial begin
      logic [31:0] d;
      int          n;

      // 1: reset with keys idle high
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rd(2'd0, d); chk("t1_data", d, 32'h0000_000F);
      rd(2'd1, d); chk("t1_dir", d, 32'h0);
      rd(2'd2, d); chk("t1_mask", d, 32'h0);
      rd(2'd3, d); chk("t1_edge", d, 32'h0);
      chk("t1_irq", {31'b0, irq}, 32'h0);
      repeat (20) @(negedge clk);
      rd(2'd3, d); chk("t1_edge_after_release", d, 32'h0);
      chk("t1_irq_after_release", {31'b0, irq}, 32'h0);

      // 2: bit0 falls and holds
      in_port = 4'hE;
      wait_level(4'hE, n);
      chk_latency("t2_latency", n);
      rd(2'd3, d); chk("t2_edge_same_cycle", d, 32'h0);
      @(negedge clk);
      rd(2'd3, d); chk("t2_edge_set", d, 32'h1);
      repeat (3) @(negedge clk);
      chk("t2_irq_masked", {31'b0, irq}, 32'h0);

      // 3: unmask, then clear
      wr(2'd2, 32'h1);
      chk("t3_irq_not_yet", {31'b0, irq}, 32'h0);
      @(negedge clk);
      chk("t3_irq_high", {31'b0, irq}, 32'h1);
      rd(2'd2, d); chk("t3_mask", d, 32'h1);
      wr(2'd3, 32'h1);
      rd(2'd3, d); chk("t3_edge_cleared", d, 32'h0);
      chk("t3_irq_still_high", {31'b0, irq}, 32'h1);
      @(negedge clk);
      chk("t3_irq_low", {31'b0, irq}, 32'h0);

      // 4: two-tick glitch on bit1 is rejected
      in_port = 4'hC;
      repeat (8) @(negedge clk);
      in_port = 4'hE;
      repeat (20) @(negedge clk);
      rd(2'd0, d); chk("t4_data", d, 32'h0000_000E);
      rd(2'd3, d); chk("t4_edge", d, 32'h0);
      chk("t4_irq", {31'b0, irq}, 32'h0);

      // 5: bit2 edge captured in the same cycle as its W1C
      in_port = 4'hA;
      wait_level(4'hA, n);
      chk_latency("t5_latency", n);
      wr(2'd3, 32'h4);
      rd(2'd3, d); chk("t5_set_wins", d, 32'h4);
      wr(2'd2, 32'h5);
      @(negedge clk);
      chk("t5_irq_unmasked", {31'b0, irq}, 32'h1);

      // 6: reset during bit3 debounce
      in_port = 4'h2;
      repeat (6) @(negedge clk);
      rd(2'd0, d); chk("t6_data_pre_reset", d, 32'h0000_000A);
      reset_n = 1'b0;
      in_port = 4'hF;
      repeat (2) @(negedge clk);
      chk("t6_irq_in_reset", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      rd(2'd0, d); chk("t6_data", d, 32'h0000_000F);
      rd(2'd2, d); chk("t6_mask", d, 32'h0);
      rd(2'd3, d); chk("t6_edge", d, 32'h0);
      chk("t6_irq", {31'b0, irq}, 32'h0);
      wr(2'd0, 32'h0);
      rd(2'd0, d); chk("t6_data_write_ignored", d, 32'h0000_000F);
      wr(2'd1, 32'hF);
      rd(2'd1, d); chk("t6_dir_write_ignored", d, 32'h0);
      repeat (30) @(negedge clk);
      rd(2'd0, d); chk("t6_data_settled", d, 32'h0000_000F);
      rd(2'd3, d); chk("t6_no_edge_from_reset", d, 32'h0);
      chk("t6_irq_settled", {31'b0, irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
